// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and default parameters for the memory port arbiter
package mem_arb_pkg;
    localparam int STATE_W = 2;
    localparam int DEF_NREQ = 2;
    localparam int DEF_AW = 4;
    localparam int DEF_DW = 16;
    localparam int DEF_MAX_BURST = 16;
    typedef enum logic [STATE_W-1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick, first set req bit at or above ptr with wrap
module rr_picker #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    // scan offsets from farthest to nearest so the nearest set bit wins
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
        gnt = |req ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port sync RAM; MEM_ARB_BURST_EN adds lock bursts
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     we,
    input  logic [NREQ*AW-1:0]  addr,
    input  logic [NREQ*DW-1:0]  wdata,
`ifdef MEM_ARB_BURST_EN
    input  logic [NREQ-1:0]     lock,
`endif
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rvalid,
    output logic [DW-1:0]       rdata,
    output logic                ram_we,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_wdata,
    input  logic [DW-1:0]       ram_rdata,
    output logic                busy
);
    localparam int IW = $clog2(NREQ);
    state_t state;
    logic [IW-1:0] winner, ptr, pick_idx, next_ptr;
    logic [NREQ-1:0] pick_gnt;
    logic finish, more;
    rr_picker #(.N(NREQ)) u_pick (.req(req), .ptr(ptr), .gnt(pick_gnt), .idx(pick_idx));
    assign finish = (state == ACCESS && we[winner]) || state == RESP;
    assign next_ptr = winner == IW'(NREQ - 1) ? '0 : winner + 1'b1;
`ifdef MEM_ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST) + 1;
    logic [CW-1:0] count;
    assign more = lock[winner] && (count + CW'(1)) < CW'(MAX_BURST);
    // completed accesses within the current grant; cleared whenever idle
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (state == IDLE) count <= '0;
        else if (finish && more) count <= count + CW'(1);
`else
    assign more = 1'b0;
`endif
    // arbitration FSM: pick in IDLE, one access cycle, optional read response cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            winner <= '0;
            ptr <= '0;
        end else begin
            case (state)
                IDLE: if (|pick_gnt) begin
                    winner <= pick_idx;
                    state <= ACCESS;
                end
                ACCESS, RESP: if (!finish) state <= RESP;
                else if (more) state <= ACCESS;
                else begin
                    state <= IDLE;
                    ptr <= next_ptr;
                end
                default: state <= IDLE;
            endcase
        end
    // RAM controls and responses decode straight from the registered state
    always_comb begin
        gnt = state == ACCESS ? NREQ'(1) << winner : '0;
        rvalid = state == RESP ? NREQ'(1) << winner : '0;
        ram_we = state == ACCESS && we[winner];
        ram_addr = state == ACCESS ? addr[int'(winner)*AW +: AW] : '0;
        ram_wdata = state == ACCESS ? wdata[int'(winner)*DW +: DW] : '0;
        rdata = state == RESP ? ram_rdata : '0;
        busy = state != IDLE;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench with a behavioural RAM; burst section needs MEM_ARB_BURST_EN
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] req = '0, we = '0, gnt, rvalid;
    logic [7:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [15:0] rdata, ram_wdata, ram_rdata;
    logic [3:0] ram_addr;
    logic ram_we, busy;
    logic [2:0] req3 = '0, we3 = '0, gnt3, rvalid3;
    logic [11:0] addr3 = '0;
    logic [47:0] wdata3 = '0;
    logic [15:0] rdata3, ram_wdata3;
    logic [3:0] ram_addr3;
    logic ram_we3, busy3;
    logic [15:0] mem [16] = '{default: 16'h0};
    int n_checks = 0;
    int n_fail = 0;
`ifdef MEM_ARB_BURST_EN
    logic [1:0] lock = '0;
    logic [2:0] lock3 = '0;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.NREQ(2), .AW(4), .DW(16), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef MEM_ARB_BURST_EN
        .lock(lock),
`endif
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy));

    mem_port_arbiter #(.NREQ(3), .AW(4), .DW(16), .MAX_BURST(4)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
`ifdef MEM_ARB_BURST_EN
        .lock(lock3),
`endif
        .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .ram_we(ram_we3), .ram_addr(ram_addr3),
        .ram_wdata(ram_wdata3), .ram_rdata(16'h0), .busy(busy3));

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] seq2 [7];
        logic [2:0] seq3 [7];
        seq2 = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        seq3 = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
        tick();
        tick();
        check("reset_outputs", {gnt, rvalid, ram_we, busy, rdata}, 0);
        check("reset_ram_bus", {ram_addr, ram_wdata}, 0);
        rst = 1'b0;
        tick();
        req = 2'b01; we = 2'b01; addr[3:0] = 4'd3; wdata[15:0] = 16'hBEEF;
        tick();
        check("wr_gnt", gnt, 2'b01);
        check("wr_ram", {ram_we, ram_addr, ram_wdata}, {1'b1, 4'd3, 16'hBEEF});
        check("wr_busy", busy, 1);
        req = 2'b00;
        tick();
        check("wr_done_busy", {busy, gnt}, 0);
        check("wr_mem3", mem[3], 16'hBEEF);
        req = 2'b10; we = 2'b00; addr[7:4] = 4'd3;
        tick();
        check("rd_gnt", {gnt, rvalid, ram_we, ram_addr}, {2'b10, 2'b00, 1'b0, 4'd3});
        req = 2'b00;
        tick();
        check("rd_rvalid", {gnt, rvalid}, {2'b00, 2'b10});
        check("rd_rdata", rdata, 16'hBEEF);
        tick();
        check("rd_idle", {busy, rvalid, rdata}, 0);
        req = 2'b11; we = 2'b11; addr = {4'd2, 4'd1}; wdata = {16'h2222, 16'h1111};
        req3 = 3'b111; we3 = 3'b111; addr3 = {4'd10, 4'd9, 4'd8};
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("alt2_%0d", i), gnt, seq2[i]);
            check($sformatf("rot3_%0d", i), gnt3, seq3[i]);
        end
        req = 2'b00; req3 = 3'b000;
        tick();
        tick();
        check("alt_mem", {mem[1], mem[2]}, {16'h1111, 16'h2222});
        req = 2'b01; we = 2'b01; addr[3:0] = 4'd7; wdata[15:0] = 16'h0007;
        tick();
        check("w7_gnt", gnt, 2'b01);
        req = 2'b00;
        tick();
        req = 2'b01; addr[3:0] = 4'd5; wdata[15:0] = 16'h1234;
        tick();
        check("rst_pre_we", ram_we, 1);
        req = 2'b00;
        #1 rst = 1'b1;
        #1;
        check("rst_async_out", {gnt, rvalid, ram_we, busy, ram_addr, ram_wdata}, 0);
        tick();
        check("rst_mem5", mem[5], 16'h0);
        rst = 1'b0;
        req = 2'b11; we = 2'b11;
        tick();
        check("rst_ptr0", gnt, 2'b01);
        req = 2'b00;
        tick();
        req = 2'b11; we = 2'b01; addr = {4'd7, 4'd4};
        tick();
        check("rw_gnt1", {gnt, rvalid}, {2'b10, 2'b00});
        req = 2'b01;
        tick();
        check("rw_rvalid1", {gnt, rvalid, rdata}, {2'b00, 2'b10, 16'h0007});
        tick();
        check("rw_gap", {gnt, rvalid}, 0);
        tick();
        check("rw_gnt0", {gnt, rvalid}, {2'b01, 2'b00});
        req = 2'b00;
        tick();
`ifdef MEM_ARB_BURST_EN
        begin
            logic [1:0] seqb [8];
            seqb = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
            req = 2'b11; we = 2'b11; lock = 2'b01;
            for (int i = 0; i < 8; i++) begin
                tick();
                check($sformatf("burst_%0d", i), gnt, seqb[i]);
            end
            req = 2'b00; lock = 2'b00;
            tick();
        end
`endif
        check("end_idle", {busy, busy3}, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Round-robin arbiter sharing one single-port synchronous RAM (1-cycle read latency) between NREQ requesters, e.g. the word loader and the result writer of the bit-extraction datapath. It owns all RAM control signals. Requesters use a req/gnt handshake, and reads return data with a per-requester rvalid pulse.

Parameters:
NREQ, 2, number of requesters (2..8)
AW, 4, RAM address width
DW, 16, RAM data width
MAX_BURST, 16, max consecutive accesses per grant (burst feature only)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req  in  NREQ  per-requester access request
we  in  NREQ  per-requester write(1)/read(0)
addr  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW]
wdata  in  NREQ*DW  flattened write data; requester i at [i*DW +: DW]
lock  in  NREQ  burst hold request; present only with MEM_ARB_BURST_EN
gnt  out  NREQ  one-hot grant; high during the cycle the access executes
rvalid  out  NREQ  one-hot pulse; rdata valid for that requester
rdata  out  DW  read data
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data; valid the cycle after a read address is presented
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: state IDLE, rr pointer 0, burst count 0. All outputs are 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Sample req.
  - If any bit is set, winner = first set bit scanning from pointer upward, wrapping modulo NREQ.
  - Register the winner and go to ACCESS.
  - If no req, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - gnt[winner]=1.
  - ram_addr/ram_we/ram_wdata = winner's addr/we/wdata (combinational mux). The write commits at the closing edge.
  - Next state: RESP if the access is a read, otherwise IDLE (burst rules below).
- RESP (exactly 1 cycle):
  - rvalid[winner]=1.
  - rdata = ram_rdata.
  - Next state: IDLE.
- ram_addr, ram_wdata, ram_we and rdata are 0 outside ACCESS/RESP respectively. No RAM write ever occurs outside ACCESS.
- Latency from req sampled in IDLE:
  - Write: gnt 1 cycle later.
  - Read: gnt 1 cycle later, rvalid 2 cycles later.
  - Throughput: 1 write per 2 cycles, 1 read per 3 cycles.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees gnt.
  - Requester drops req in the cycle after gnt, unless it wants another access.
  - req is ignored outside IDLE.
- Pointer update: pointer <= (winner+1) mod NREQ when leaving ACCESS (write) or RESP (read). A requester that just won has lowest priority next time.
- Simultaneous requests are served in strict rotation. No requester waits more than NREQ-1 other grants.
- Reset mid-operation: abort immediately to IDLE.
  - An in-flight write is dropped if rst asserts before its commit edge.
  - A pending rvalid is not produced.

Optional Feature:
MEM_ARB_BURST_EN:
- Adds the lock port and a burst counter (width clog2(MAX_BURST)+1).
- Where the base rules go to IDLE after a completed access, the arbiter instead goes back to ACCESS with the same winner if both hold:
  - lock[winner]=1 is sampled at that point;
  - the completed-access count is below MAX_BURST.
- The pointer is not updated until the burst ends.
- The requester presents its next addr/we/wdata in the cycle after each gnt (write) or rvalid (read).
- Count resets in IDLE.
Without the macro: no lock port; every access returns to IDLE, as above.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ACCESS, RESP), state width constant, default parameter constants.
- Sub-module rr_picker: combinational; inputs req vector and pointer, outputs one-hot grant and encoded index. It is reused by the other arbiters in the design.

Test Plan:
- Req0 write addr 3, data 0xBEEF alone -> gnt[0] 1 cycle later, ram_we=1, ram_addr=3, ram_wdata=0xBEEF; busy falls the following cycle.
- Req1 read addr 3 after the above -> gnt[1] at +1, rvalid[1] at +2 with rdata=0xBEEF, then IDLE.
- Req0 and req1 held continuously with writes -> grants alternate 0,1,0,1. Repeat with NREQ=3: order 0,1,2,0 confirms wrap.
- Assert rst during ACCESS of a write to addr 5 -> ram_we drops immediately, RAM[5] unchanged, all outputs 0, pointer back to 0.
- Burst: MEM_ARB_BURST_EN, MAX_BURST=4, req0+lock0 with writes while req1 pending -> exactly 4 consecutive gnt[0], then gnt[1].
- Read while the other requester is pending a write -> rvalid precedes the other requester's gnt; no overlap of gnt and rvalid.
